// File: rtl/pp_buf_pkg.sv
// Shared types for the ping-pong stage buffer reader.
package pp_buf_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} pp_rd_state_e;

  localparam int PP_BUF_NUM = 2;

  function automatic logic pp_next_bank(input logic bank);
    return (int'(bank) == PP_BUF_NUM - 1) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/pp_skid_fifo.sv
// Register-based FIFO; dout shows the head combinationally, one-cycle push-to-visible.
// Push is refused only when full with no pop in the same cycle; pop on empty is ignored.
module pp_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pp_buf_rd.sv
// Drains one full ping-pong bank in address order into a valid/ready stream.
// Reads are credit-gated on FIFO room so BRAM latency is absorbed under backpressure.
module pp_buf_rd
  import pp_buf_pkg::*;
#(
  parameter int CNT_NUM      = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 512,
  parameter int BRAM_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_vld,
  output logic                  st_ren,
  output logic                  st_rsel,
  output logic [ADDR_WIDTH-1:0] st_raddr,
  input  logic [DATA_WIDTH-1:0] st_rdata,
  output logic                  st_rd_done,
  output logic                  aft_st_vld,
  output logic [DATA_WIDTH-1:0] aft_st_data,
  output logic                  aft_st_last,
  input  logic                  aft_st_rdy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(BRAM_LATENCY + 1) + 1;
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CNT_NUM - 1);

  pp_rd_state_e          state_q;
  pp_rd_state_e          state_d;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic                  rsel_q;
  logic                  rsel_d;
  logic [INF_W-1:0]      inflight_q;
  logic [INF_W-1:0]      inflight_d;
  logic [BRAM_LATENCY-1:0] ren_pipe_q;
  logic [BRAM_LATENCY-1:0] last_pipe_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [SUM_W-1:0]      occupancy;
  logic                  issue_last;
  logic                  cap_vld;
  logic                  cap_last;

  // Every issued read already owns a FIFO slot, so captures can never overflow.
  assign occupancy  = SUM_W'(fifo_count) + SUM_W'(inflight_q);
  assign st_ren     = (state_q == READ) && (occupancy < SUM_W'(FIFO_DEPTH));
  assign issue_last = st_ren && (raddr_q == LAST_ADDR);
  assign cap_vld    = ren_pipe_q[BRAM_LATENCY-1];
  assign cap_last   = last_pipe_q[BRAM_LATENCY-1];

  assign st_rsel    = rsel_q;
  assign st_raddr   = raddr_q;
  assign st_rd_done = (state_q == DONE);

  assign aft_st_vld = !fifo_empty;
  assign fifo_pop   = aft_st_vld && aft_st_rdy;
  assign {aft_st_last, aft_st_data} = fifo_dout;

  assign inflight_d = inflight_q + INF_W'(st_ren) - INF_W'(cap_vld);

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rsel_d  = rsel_q;
    case (state_q)
      IDLE: begin
        if (st_vld) state_d = READ;
      end
      READ: begin
        if (st_ren) raddr_d = raddr_q + ADDR_WIDTH'(1);
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = DONE;
          raddr_d = '0;
        end
      end
      DONE: begin
        // The writer's flag lags by a cycle, so st_vld is not looked at here.
        state_d = IDLE;
        rsel_d  = pp_next_bank(rsel_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      rsel_q      <= 1'b0;
      inflight_q  <= '0;
      ren_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q        <= state_d;
      raddr_q        <= raddr_d;
      rsel_q         <= rsel_d;
      inflight_q     <= inflight_d;
      ren_pipe_q[0]  <= st_ren;
      last_pipe_q[0] <= issue_last;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        ren_pipe_q[i]  <= ren_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  pp_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_vld),
    .pop   (fifo_pop),
    .din   ({cap_last, st_rdata}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(cap_vld && !fifo_pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= INF_W'(BRAM_LATENCY));

endmodule

// File: tb/tb_pp_buf_rd.sv
// Bench for pp_buf_rd: directed scenarios on a latency-2 build, random backpressure on a latency-1 build.
module tb_pp_buf_rd;

  localparam int CNT = 8;
  localparam int AW  = 3;
  localparam int DW  = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: BRAM_LATENCY=2, FIFO_DEPTH=4 ----------------
  logic          rst_a, a_st_vld, a_ren, a_rsel, a_done, a_vld, a_last, a_rdy;
  logic [AW-1:0] a_raddr;
  logic [DW-1:0] a_rdata = '0;
  logic [DW-1:0] a_dat;

  pp_buf_rd #(.CNT_NUM(CNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
              .BRAM_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .st_vld(a_st_vld), .st_ren(a_ren), .st_rsel(a_rsel),
    .st_raddr(a_raddr), .st_rdata(a_rdata), .st_rd_done(a_done),
    .aft_st_vld(a_vld), .aft_st_data(a_dat), .aft_st_last(a_last), .aft_st_rdy(a_rdy));

  logic          a_p1_vld = 1'b0;
  logic [DW-1:0] a_p1 = '0;
  always @(posedge clk) begin
    a_p1_vld <= a_ren;
    a_p1     <= DW'({a_rsel, a_raddr});
    a_rdata  <= a_p1_vld ? a_p1 : 16'hDEAD;
  end

  exp_t qa[$];
  int   a_bank = 0;
  int   a_ren_cnt = 0, a_done_cnt = 0, a_word_cnt = 0;
  logic a_hold = 1'b0;
  exp_t a_held, a_e;

  always @(negedge clk) begin
    if (rst_a) begin
      a_hold = 1'b0;
    end else begin
      if (a_ren) a_ren_cnt++;
      if (a_done) a_done_cnt++;
      if (a_hold) begin
        check_eq("a_hold_vld", a_vld, 1);
        check_eq("a_hold_word", longint'({a_last, a_dat}), longint'(a_held));
      end
      a_hold = a_vld && !a_rdy;
      a_held = {a_last, a_dat};
      if (a_vld && a_rdy) begin
        check_eq("a_word_expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          a_e = qa.pop_front();
          check_eq("a_data", a_dat, a_e.dat);
          check_eq("a_last", a_last, a_e.last);
          a_word_cnt++;
        end
      end
    end
  end

  task automatic expect_bank_a();
    for (int i = 0; i < CNT; i++) qa.push_back(exp_t'{last: (i == CNT - 1), dat: DW'(a_bank * CNT + i)});
    a_bank = 1 - a_bank;
  endtask

  task automatic zero_a(input string tag);
    check_eq({tag, "_ren"}, a_ren, 0);
    check_eq({tag, "_done"}, a_done, 0);
    check_eq({tag, "_vld"}, a_vld, 0);
    check_eq({tag, "_last"}, a_last, 0);
    check_eq({tag, "_raddr"}, a_raddr, 0);
    check_eq({tag, "_data"}, a_dat, 0);
    check_eq({tag, "_rsel"}, a_rsel, 0);
  endtask

  task automatic reset_a();
    rst_a = 1'b1; a_st_vld = 1'b0; qa.delete(); a_bank = 0;
    tick(); tick();
    zero_a("rst");
    rst_a = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int cyc = 0;
    while ((qa.size() != 0 || a_vld) && cyc < 500) begin tick(); cyc++; end
    check_eq(name, cyc < 500, 1);
    repeat (6) tick();
  endtask

  task automatic first_ren_a(input string name, input int bank);
    int cyc = 0;
    while (!a_ren && cyc < 50) begin tick(); cyc++; end
    check_eq({name, "_seen"}, a_ren, 1);
    check_eq({name, "_addr"}, a_raddr, 0);
    check_eq({name, "_bank"}, a_rsel, bank);
  endtask

  // ---------------- instance B: BRAM_LATENCY=1, FIFO_DEPTH=2 ----------------
  logic          rst_b, b_st_vld, b_ren, b_rsel, b_done, b_vld, b_last, b_rdy;
  logic [AW-1:0] b_raddr;
  logic [DW-1:0] b_rdata = '0;
  logic [DW-1:0] b_dat;
  logic          b_fin = 1'b0;

  pp_buf_rd #(.CNT_NUM(CNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
              .BRAM_LATENCY(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .st_vld(b_st_vld), .st_ren(b_ren), .st_rsel(b_rsel),
    .st_raddr(b_raddr), .st_rdata(b_rdata), .st_rd_done(b_done),
    .aft_st_vld(b_vld), .aft_st_data(b_dat), .aft_st_last(b_last), .aft_st_rdy(b_rdy));

  always @(posedge clk) b_rdata <= b_ren ? DW'({b_rsel, b_raddr}) : 16'hDEAD;

  exp_t qb[$];
  int   b_word_cnt = 0, b_done_cnt = 0;
  logic b_hold = 1'b0;
  exp_t b_held, b_e;

  always @(negedge clk) begin
    if (rst_b) begin
      b_hold = 1'b0;
    end else begin
      if (b_done) b_done_cnt++;
      if (b_hold) check_eq("b_hold_word", longint'({b_vld, b_last, b_dat}), longint'({1'b1, b_held}));
      b_hold = b_vld && !b_rdy;
      b_held = {b_last, b_dat};
      if (b_vld && b_rdy) begin
        check_eq("b_word_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          b_e = qb.pop_front();
          check_eq("b_data", b_dat, b_e.dat);
          check_eq("b_last", b_last, b_e.last);
          b_word_cnt++;
        end
      end
    end
  end

  initial begin
    rst_b = 1'b1; b_st_vld = 1'b0; b_rdy = 1'b0;
    for (int k = 0; k < 130; k++)
      for (int i = 0; i < CNT; i++) qb.push_back(exp_t'{last: (i == CNT - 1), dat: DW'((k % 2) * CNT + i)});
    tick(); tick();
    rst_b = 1'b0; b_st_vld = 1'b1;
    repeat (1000) begin
      tick();
      b_rdy = 1'($urandom_range(0, 1));
    end
    check_eq("b_enough_words", b_word_cnt >= 100, 1);
    check_eq("b_done_per_bank", b_done_cnt >= b_word_cnt / CNT, 1);
    b_fin = 1'b1;
  end

  // ---------------- directed scenarios on A ----------------
  initial begin
    int cyc, run, r0, d0, w0;
    rst_a = 1'b1; a_st_vld = 1'b0; a_rdy = 1'b0;

    // Continuous flow: bank 0 back-to-back, then writer idles, then bank 1.
    reset_a();
    a_rdy = 1'b1; w0 = a_word_cnt; d0 = a_done_cnt;
    expect_bank_a(); a_st_vld = 1'b1;
    cyc = 0;
    while (!a_vld && cyc < 50) begin tick(); cyc++; end
    check_eq("s1_first_vld", a_vld, 1);
    run = 0;
    repeat (CNT) begin run += int'(a_vld); tick(); end
    check_eq("s1_back_to_back", run, CNT);
    cyc = 0;
    while (!a_done && cyc < 50) begin tick(); cyc++; end
    check_eq("s1_done_seen", a_done, 1);
    tick(); a_st_vld = 1'b0;
    r0 = a_ren_cnt;
    repeat (10) tick();
    check_eq("s1_idle_no_ren", a_ren_cnt - r0, 0);
    check_eq("s1_one_done", a_done_cnt - d0, 1);
    check_eq("s1_bank0_words", a_word_cnt - w0, CNT);
    expect_bank_a(); a_st_vld = 1'b1;
    first_ren_a("s1_resume", 1);
    a_st_vld = 1'b0;
    drain_a("s1_drain_bank1");
    check_eq("s1_two_done", a_done_cnt - d0, 2);

    // Backpressure from reset: credit limit caps issued reads.
    a_rdy = 1'b0;
    reset_a();
    w0 = a_word_cnt; d0 = a_done_cnt;
    expect_bank_a(); a_st_vld = 1'b1;
    r0 = a_ren_cnt;
    repeat (20) tick();
    a_st_vld = 1'b0;
    check_eq("s2_ren_stall", a_ren_cnt - r0, 4);
    check_eq("s2_vld_held", a_vld, 1);
    check_eq("s2_word0", a_dat, 0);
    check_eq("s2_word0_last", a_last, 0);
    a_rdy = 1'b1;
    drain_a("s2_drain");
    check_eq("s2_words", a_word_cnt - w0, CNT);
    check_eq("s2_done", a_done_cnt - d0, 1);

    // Toggling ready across three banks.
    reset_a();
    a_rdy = 1'b1; w0 = a_word_cnt; d0 = a_done_cnt; r0 = a_ren_cnt;
    repeat (3) expect_bank_a();
    a_st_vld = 1'b1;
    cyc = 0;
    while ((qa.size() != 0 || a_done_cnt - d0 < 3) && cyc < 800) begin
      tick(); cyc++;
      a_rdy = !a_rdy;
      if (a_ren_cnt - r0 > 2 * CNT) a_st_vld = 1'b0;
    end
    check_eq("s3_complete", cyc < 800, 1);
    a_rdy = 1'b1;
    repeat (6) tick();
    check_eq("s3_words", a_word_cnt - w0, 3 * CNT);
    check_eq("s3_done", a_done_cnt - d0, 3);
    check_eq("s3_reads", a_ren_cnt - r0, 3 * CNT);

    // Reset in the middle of bank 0.
    reset_a();
    a_rdy = 1'b1;
    expect_bank_a(); a_st_vld = 1'b1;
    r0 = a_ren_cnt;
    cyc = 0;
    while (a_ren_cnt - r0 < 5 && cyc < 50) begin tick(); cyc++; end
    check_eq("s4_five_reads", a_ren_cnt - r0 >= 5, 1);
    d0 = a_done_cnt; w0 = a_word_cnt;
    rst_a = 1'b1; qa.delete(); a_bank = 0;
    tick();
    zero_a("s4_midrst");
    rst_a = 1'b0;
    expect_bank_a();
    first_ren_a("s4_restart", 0);
    a_st_vld = 1'b0;
    drain_a("s4_drain");
    check_eq("s4_words", a_word_cnt - w0, CNT);
    check_eq("s4_done", a_done_cnt - d0, 1);

    cyc = 0;
    while (!b_fin && cyc < 3000) begin tick(); cyc++; end
    check_eq("b_run_finished", b_fin, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
